instruction_encode: RTL and testbench

- Inverse of the RV32I decode stage: packs opcode, funct7, funct3, immediate and register fields into a 32-bit RV32I instruction word.
- Sits between the self-check/test-program generator and instruction memory; its output feeds the decoder for round-trip checking.
- Input and output are valid/ready streams. Output is registered, with a one-entry skid buffer so throughput is one instruction per cycle.
- Flags fields that cannot be represented and keeps accept/error counters.

---
 rtl/instruction_encode.sv | 182 ++++++++++++++++++
 tb/tb_instruction_encode.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_encode.sv
// RV32I instruction encoder: packs opcode/funct/register/immediate fields into
// a 32-bit instruction word. The input is a valid/ready stream, and so is the
// registered output. A one-entry skid buffer keeps throughput at one word per
// cycle. Fields that cannot be represented raise o_error, and accept/error
// counters are kept.
module instruction_encode #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [6:0]       i_opcode,
  input  logic [6:0]       i_funct7,
  input  logic [2:0]       i_funct3,
  input  logic [XLEN-1:0]  i_immediate,
  input  logic [4:0]       i_rs1_raddr,
  input  logic [4:0]       i_rs2_raddr,
  input  logic [4:0]       i_rd_waddr,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [XLEN-1:0]  o_instruction,
  output logic             o_error,
  output logic [CNT_W-1:0] o_accept_count,
  output logic [CNT_W-1:0] o_error_count
);

  localparam logic [6:0] OP_R_INT    = 7'b0110011;
  localparam logic [6:0] OP_I_INT    = 7'b0010011;
  localparam logic [6:0] OP_I_JUMP   = 7'b1100111;
  localparam logic [6:0] OP_I_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_S_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_S_STORE  = 7'b0100011;
  localparam logic [6:0] OP_U_IMM    = 7'b0110111;
  localparam logic [6:0] OP_U_PC     = 7'b0010111;
  localparam logic [6:0] OP_U_JUMP   = 7'b1101111;

  // Immediate range checks. An immediate fits in N signed bits exactly when
  // everything from bit N-1 upward is one copy of the sign.
  // Index 0: 12-bit I/S, 1: 13-bit B, 2: 21-bit J.
  logic signed [XLEN-1:0] imm_s;
  logic [2:0]             fits;

  assign imm_s = signed'(i_immediate);

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_fit
      localparam int SHIFT = (gi == 0) ? 11 : ((gi == 1) ? 12 : 20);
      logic [XLEN-1:0] upper;
      assign upper    = imm_s >>> SHIFT;
      assign fits[gi] = (upper == '0) || (&upper);
    end
  endgenerate

  logic            is_shift;
  logic            shift_f7_ok;
  logic [XLEN-1:0] enc_word;
  logic            enc_err;

  assign is_shift    = (i_opcode == OP_I_INT) &&
                       ((i_funct3 == 3'b001) || (i_funct3 == 3'b101));
  assign shift_f7_ok = (i_funct7 == 7'b0000000) || (i_funct7 == 7'b0100000);

  // Combinational encode of the current input fields into a word plus an error flag.
  always_comb begin
    enc_word = '0;
    enc_err  = 1'b0;
    case (i_opcode)
      OP_R_INT: begin
        enc_word[31:0] = {i_funct7, i_rs2_raddr, i_rs1_raddr, i_funct3,
                          i_rd_waddr, i_opcode};
      end
      OP_I_INT, OP_I_JUMP, OP_I_LOAD: begin
        enc_word[31:0] = {i_immediate[11:0], i_rs1_raddr, i_funct3,
                          i_rd_waddr, i_opcode};
        enc_err = !fits[0];
        if (is_shift) begin
          // Shifts carry shamt in the low immediate bits; funct7 selects logical/arith.
          enc_word[31:25] = i_funct7;
          enc_word[24:20] = i_immediate[4:0];
          if (!shift_f7_ok) begin
            enc_err = 1'b1;
          end
        end
      end
      OP_S_STORE: begin
        enc_word[31:0] = {i_immediate[11:5], i_rs2_raddr, i_rs1_raddr,
                          i_funct3, i_immediate[4:0], i_opcode};
        enc_err = !fits[0];
      end
      OP_S_BRANCH: begin
        enc_word[31:0] = {i_immediate[12], i_immediate[10:5], i_rs2_raddr,
                          i_rs1_raddr, i_funct3, i_immediate[4:1],
                          i_immediate[11], i_opcode};
        enc_err = !fits[1] || i_immediate[0];
      end
      OP_U_IMM, OP_U_PC: begin
        enc_word[31:0] = {i_immediate[31:12], i_rd_waddr, i_opcode};
        enc_err = (i_immediate[11:0] != 12'd0);
      end
      OP_U_JUMP: begin
        enc_word[31:0] = {i_immediate[20], i_immediate[10:1], i_immediate[11],
                          i_immediate[19:12], i_rd_waddr, i_opcode};
        enc_err = !fits[2] || i_immediate[0];
      end
      default: begin
        // Unknown opcode: emit an all-zero word flagged as an error.
        enc_word = '0;
        enc_err  = 1'b1;
      end
    endcase
  end

  logic            out_valid_reg;
  logic [XLEN-1:0] out_instr_reg;
  logic            out_error_reg;
  logic            skid_valid_reg;
  logic [XLEN-1:0] skid_instr_reg;
  logic            skid_error_reg;
  logic            accept;
  logic            drain;

  // Reset is folded into ready so that no handshake can complete in a reset cycle.
  assign o_ready = !skid_valid_reg && !rst;
  assign accept  = i_valid && o_ready;
  assign drain   = out_valid_reg && i_ready;

  // Output register with skid: refill the output from the skid first, then from the input.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg  <= 1'b0;
      out_instr_reg  <= '0;
      out_error_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
      skid_instr_reg <= '0;
      skid_error_reg <= 1'b0;
    end else if (!out_valid_reg || drain) begin
      if (skid_valid_reg) begin
        out_valid_reg  <= 1'b1;
        out_instr_reg  <= skid_instr_reg;
        out_error_reg  <= skid_error_reg;
        skid_valid_reg <= 1'b0;
      end else if (accept) begin
        out_valid_reg <= 1'b1;
        out_instr_reg <= enc_word;
        out_error_reg <= enc_err;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end else if (accept) begin
      // Output is stalled: park the new word; o_ready drops next cycle.
      skid_valid_reg <= 1'b1;
      skid_instr_reg <= enc_word;
      skid_error_reg <= enc_err;
    end
  end

  logic [CNT_W-1:0] accept_count_reg;
  logic [CNT_W-1:0] error_count_reg;

  // Accept counter wraps; error counter sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      accept_count_reg <= '0;
      error_count_reg  <= '0;
    end else if (accept) begin
      accept_count_reg <= accept_count_reg + CNT_W'(1);
      if (enc_err && (error_count_reg != '1)) begin
        error_count_reg <= error_count_reg + CNT_W'(1);
      end
    end
  end

  assign o_valid        = out_valid_reg;
  assign o_instruction  = out_instr_reg;
  assign o_error        = out_error_reg;
  assign o_accept_count = accept_count_reg;
  assign o_error_count  = error_count_reg;

endmodule

// File: tb/tb_instruction_encode.sv
// Bench for instruction_encode: arithmetic reference encoder + queue scoreboard,
// a standalone decoder for round-trip checks, and directed literal expectations.
module tb_instruction_encode;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [6:0]  i_opcode = '0;
  logic [6:0]  i_funct7 = '0;
  logic [2:0]  i_funct3 = '0;
  logic [31:0] i_immediate = '0;
  logic [4:0]  i_rs1_raddr = '0;
  logic [4:0]  i_rs2_raddr = '0;
  logic [4:0]  i_rd_waddr = '0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [31:0] o_instruction;
  logic        o_error;
  logic [15:0] o_accept_count;
  logic [15:0] o_error_count;

  instruction_encode #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_opcode(i_opcode), .i_funct7(i_funct7), .i_funct3(i_funct3),
    .i_immediate(i_immediate), .i_rs1_raddr(i_rs1_raddr),
    .i_rs2_raddr(i_rs2_raddr), .i_rd_waddr(i_rd_waddr),
    .o_valid(o_valid), .i_ready(i_ready), .o_instruction(o_instruction),
    .o_error(o_error), .o_accept_count(o_accept_count),
    .o_error_count(o_error_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference encoder written from the field-placement rules with plain arithmetic.
  function automatic void model_enc(input logic [6:0] opc, input logic [6:0] f7,
                                    input logic [2:0] f3, input logic [31:0] imm,
                                    input logic [4:0] rs1, input logic [4:0] rs2,
                                    input logic [4:0] rd,
                                    output logic [31:0] w, output logic e);
    longint s;
    logic [31:0] o, d, t3, r1, r2, t7;
    s  = longint'($signed(imm));
    o  = 32'(opc); d = 32'(rd); t3 = 32'(f3); r1 = 32'(rs1); r2 = 32'(rs2); t7 = 32'(f7);
    w = 32'd0;
    e = 1'b0;
    case (opc)
      OP_R: w = o | (d << 7) | (t3 << 12) | (r1 << 15) | (r2 << 20) | (t7 << 25);
      OP_I, OP_JR, OP_LD: begin
        w = o | (d << 7) | (t3 << 12) | (r1 << 15) | ((imm & 32'hFFF) << 20);
        e = (s < -2048) || (s > 2047);
        if (opc == OP_I && (f3 == 3'b001 || f3 == 3'b101)) begin
          w = (w & 32'h000FFFFF) | ((imm & 32'd31) << 20) | (t7 << 25);
          if (f7 != 7'h00 && f7 != 7'h20) e = 1'b1;
        end
      end
      OP_ST: begin
        w = o | ((imm & 32'd31) << 7) | (t3 << 12) | (r1 << 15) | (r2 << 20) |
            (((imm >> 5) & 32'd127) << 25);
        e = (s < -2048) || (s > 2047);
      end
      OP_BR: begin
        w = o | (((imm >> 11) & 32'd1) << 7) | (((imm >> 1) & 32'd15) << 8) |
            (t3 << 12) | (r1 << 15) | (r2 << 20) | (((imm >> 5) & 32'd63) << 25) |
            (((imm >> 12) & 32'd1) << 31);
        e = (s < -4096) || (s > 4095) || ((s % 2) != 0);
      end
      OP_LUI, OP_AUI: begin
        w = o | (d << 7) | (imm & 32'hFFFFF000);
        e = (imm & 32'hFFF) != 32'd0;
      end
      OP_JAL: begin
        w = o | (d << 7) | (imm & 32'h000FF000) | (((imm >> 11) & 32'd1) << 20) |
            (((imm >> 1) & 32'd1023) << 21) | (((imm >> 20) & 32'd1) << 31);
        e = (s < -1048576) || (s > 1048575) || ((s % 2) != 0);
      end
      default: begin
        w = 32'd0;
        e = 1'b1;
      end
    endcase
  endfunction

  function automatic logic is_shift(input logic [6:0] opc, input logic [2:0] f3);
    return (opc == OP_I) && (f3 == 3'b001 || f3 == 3'b101);
  endfunction

  // Fields a decoder can recover for this format: {opc,rd,f3,rs1,rs2,f7,imm}.
  function automatic logic [63:0] want_fields(input logic [6:0] opc, input logic [6:0] f7,
                                              input logic [2:0] f3, input logic [31:0] imm,
                                              input logic [4:0] rs1, input logic [4:0] rs2,
                                              input logic [4:0] rd);
    logic [4:0] a_rd, a_rs1, a_rs2;
    logic [2:0] a_f3;
    logic [6:0] a_f7;
    logic [31:0] a_imm;
    a_rd = '0; a_rs1 = '0; a_rs2 = '0; a_f3 = '0; a_f7 = '0; a_imm = '0;
    case (opc)
      OP_R: begin a_rd = rd; a_f3 = f3; a_rs1 = rs1; a_rs2 = rs2; a_f7 = f7; end
      OP_I, OP_JR, OP_LD: begin
        a_rd = rd; a_f3 = f3; a_rs1 = rs1; a_imm = imm;
        if (is_shift(opc, f3)) begin a_f7 = f7; a_imm = imm & 32'd31; end
      end
      OP_ST, OP_BR: begin a_f3 = f3; a_rs1 = rs1; a_rs2 = rs2; a_imm = imm; end
      OP_LUI, OP_AUI, OP_JAL: begin a_rd = rd; a_imm = imm; end
      default: ;
    endcase
    return {opc, a_rd, a_f3, a_rs1, a_rs2, a_f7, a_imm};
  endfunction

  // Independent RV32I decoder used for the round-trip comparison.
  function automatic logic [63:0] decode_word(input logic [31:0] w);
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] imm;
    rd = '0; rs1 = '0; rs2 = '0; f3 = '0; f7 = '0; imm = '0;
    case (w[6:0])
      OP_R: begin rd = w[11:7]; f3 = w[14:12]; rs1 = w[19:15]; rs2 = w[24:20]; f7 = w[31:25]; end
      OP_I, OP_JR, OP_LD: begin
        rd = w[11:7]; f3 = w[14:12]; rs1 = w[19:15];
        imm = {{20{w[31]}}, w[31:20]};
        if (is_shift(w[6:0], w[14:12])) begin f7 = w[31:25]; imm = {27'd0, w[24:20]}; end
      end
      OP_ST: begin
        f3 = w[14:12]; rs1 = w[19:15]; rs2 = w[24:20];
        imm = {{20{w[31]}}, w[31:25], w[11:7]};
      end
      OP_BR: begin
        f3 = w[14:12]; rs1 = w[19:15]; rs2 = w[24:20];
        imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      end
      OP_LUI, OP_AUI: begin rd = w[11:7]; imm = {w[31:12], 12'd0}; end
      OP_JAL: begin rd = w[11:7]; imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0}; end
      default: ;
    endcase
    return {w[6:0], rd, f3, rs1, rs2, f7, imm};
  endfunction

  typedef struct {
    logic [31:0] word;
    logic        err;
    logic [63:0] fields;
  } exp_t;

  exp_t        q[$];
  logic [15:0] exp_acc = '0;
  logic [15:0] exp_err = '0;
  logic        armed = 1'b0;
  logic        saw_not_ready = 1'b0;
  int          n_xfer = 0;

  // Scoreboard: compare every cycle at the falling edge, then advance the model
  // by the handshakes that the next rising edge will complete.
  always @(negedge clk) begin
    logic exp_ready;
    exp_t e;
    exp_ready = !rst && (q.size() < 2);
    if (armed) begin
      check("o_ready", 64'(o_ready), 64'(exp_ready));
      check("o_valid", 64'(o_valid), 64'(q.size() > 0));
      if (q.size() > 0) begin
        check("o_instruction", 64'(o_instruction), 64'(q[0].word));
        check("o_error", 64'(o_error), 64'(q[0].err));
      end
      check("accept_count", 64'(o_accept_count), 64'(exp_acc));
      check("error_count", 64'(o_error_count), 64'(exp_err));
      if (!o_ready && !rst) saw_not_ready = 1'b1;
    end
    if (rst) begin
      armed = 1'b1;
      q.delete();
      exp_acc = '0;
      exp_err = '0;
    end else if (armed) begin
      if (q.size() > 0 && i_ready) begin
        e = q.pop_front();
        $display("xfer %0d: instr=%08h err=%0b", n_xfer, o_instruction, o_error);
        n_xfer++;
        if (!e.err) check("roundtrip", decode_word(o_instruction), e.fields);
      end
      if (i_valid && exp_ready) begin
        model_enc(i_opcode, i_funct7, i_funct3, i_immediate, i_rs1_raddr,
                  i_rs2_raddr, i_rd_waddr, e.word, e.err);
        e.fields = want_fields(i_opcode, i_funct7, i_funct3, i_immediate,
                               i_rs1_raddr, i_rs2_raddr, i_rd_waddr);
        q.push_back(e);
        exp_acc = exp_acc + 16'd1;
        if (e.err && exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
      end
    end
  end

  // Present one field set and hold it until it is accepted (bounded wait).
  task automatic send(input logic [6:0] opc, input logic [6:0] f7, input logic [2:0] f3,
                      input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd);
    logic acc;
    int   tries;
    i_valid = 1'b1; i_opcode = opc; i_funct7 = f7; i_funct3 = f3;
    i_immediate = imm; i_rs1_raddr = rs1; i_rs2_raddr = rs2; i_rd_waddr = rd;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 64) begin
      @(negedge clk);
      acc = o_ready;
      @(posedge clk);
      #1;
      tries++;
    end
    check("send_accepted", 64'(acc), 64'd1);
  endtask

  task automatic idle();
    i_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drained", 64'(q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_ready", 64'(o_ready), 64'd0);
    check("rst_acc_cnt", 64'(o_accept_count), 64'd0);
    check("rst_err_cnt", 64'(o_error_count), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("ready_after_rst", 64'(o_ready), 64'd1);
  endtask

  task automatic rand_send();
    logic [31:0] r;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [31:0] imm;
    r   = $urandom;
    f7  = r[6:0];
    f3  = r[9:7];
    r   = $urandom;
    imm = r;
    case ($urandom_range(0, 8))
      0: opc = OP_R;
      1: opc = OP_I;
      2: opc = OP_JR;
      3: opc = OP_LD;
      4: opc = OP_BR;
      5: opc = OP_ST;
      6: opc = OP_LUI;
      7: opc = OP_AUI;
      default: opc = OP_JAL;
    endcase
    case (opc)
      OP_I, OP_JR, OP_LD, OP_ST: begin
        imm = {{20{r[11]}}, r[11:0]};
        if (is_shift(opc, f3)) begin
          f7  = {1'b0, r[20], 5'd0};
          imm = {27'd0, r[4:0]};
        end
      end
      OP_BR:         imm = {{19{r[12]}}, r[12:1], 1'b0};
      OP_LUI, OP_AUI: imm = {r[31:12], 12'd0};
      OP_JAL:        imm = {{11{r[20]}}, r[20:1], 1'b0};
      default: ;
    endcase
    r = $urandom;
    send(opc, f7, f3, imm, r[4:0], r[9:5], r[14:10]);
    if ($urandom_range(0, 4) == 0) begin
      idle();
      @(posedge clk);
      #1;
    end
  endtask

  logic [31:0] mw;
  logic        me;
  logic        rand_done;

  initial begin
    // Pin the reference model to hand-computed words.
    model_enc(OP_I, 7'd0, 3'd0, 32'd5, 5'd0, 5'd0, 5'd1, mw, me);
    check("model_addi", 64'(mw), 64'h00500093);
    model_enc(OP_BR, 7'd0, 3'd0, 32'hFFFFFFFC, 5'd1, 5'd2, 5'd0, mw, me);
    check("model_beq", 64'(mw), 64'hFE208EE3);
    model_enc(OP_JAL, 7'd0, 3'd0, 32'd2048, 5'd0, 5'd0, 5'd1, mw, me);
    check("model_jal", 64'(mw), 64'h001000EF);
    model_enc(OP_LUI, 7'd0, 3'd0, 32'h12345000, 5'd0, 5'd0, 5'd5, mw, me);
    check("model_lui", 64'(mw), 64'h123452B7);
    model_enc(OP_I, 7'd0, 3'd0, 32'd2048, 5'd0, 5'd0, 5'd1, mw, me);
    check("model_addi_err", 64'(me), 64'd1);

    // Power-on reset.
    repeat (3) @(posedge clk);
    #1;
    check("por_valid", 64'(o_valid), 64'd0);
    check("por_instr", 64'(o_instruction), 64'd0);
    check("por_error", 64'(o_error), 64'd0);
    check("por_acc_cnt", 64'(o_accept_count), 64'd0);
    rst = 1'b0;
    #1;
    check("por_ready_after", 64'(o_ready), 64'd1);

    // Directed encodings, visible one cycle after accept.
    send(OP_I, 7'd0, 3'd0, 32'd5, 5'd0, 5'd0, 5'd1);
    check("addi_valid", 64'(o_valid), 64'd1);
    check("addi_word", 64'(o_instruction), 64'h00500093);
    check("addi_err", 64'(o_error), 64'd0);
    send(OP_BR, 7'd0, 3'd0, 32'hFFFFFFFC, 5'd1, 5'd2, 5'd0);
    check("beq_word", 64'(o_instruction), 64'hFE208EE3);
    send(OP_JAL, 7'd0, 3'd0, 32'd2048, 5'd0, 5'd0, 5'd1);
    check("jal_word", 64'(o_instruction), 64'h001000EF);
    send(OP_LUI, 7'd0, 3'd0, 32'h12345000, 5'd0, 5'd0, 5'd5);
    check("lui_word", 64'(o_instruction), 64'h123452B7);
    idle();
    wait_drain();

    // Back-to-back burst with a 3-cycle downstream stall.
    do_reset();
    saw_not_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 8; k++) send(OP_I, 7'd0, 3'd0, 32'(k + 1), 5'd2, 5'd0, 5'(k));
        idle();
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        i_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        i_ready = 1'b1;
      end
    join
    wait_drain();
    check("burst_acc_cnt", 64'(o_accept_count), 64'd8);
    check("burst_ready_dropped", 64'(saw_not_ready), 64'd1);

    // Representability errors.
    do_reset();
    send(OP_I, 7'd0, 3'd0, 32'd2048, 5'd0, 5'd0, 5'd1);
    check("err_addi_2048", 64'(o_error), 64'd1);
    send(OP_BR, 7'd0, 3'd0, 32'd3, 5'd1, 5'd2, 5'd0);
    check("err_branch_odd", 64'(o_error), 64'd1);
    send(7'h7F, 7'd0, 3'd0, 32'd0, 5'd1, 5'd2, 5'd3);
    check("err_opcode_err", 64'(o_error), 64'd1);
    check("err_opcode_word", 64'(o_instruction), 64'd0);
    check("err_count", 64'(o_error_count), 64'd3);
    idle();
    wait_drain();

    // Reset with the output register and skid both full.
    i_ready = 1'b0;
    send(OP_LUI, 7'd0, 3'd0, 32'hABCDE000, 5'd0, 5'd0, 5'd7);
    send(OP_AUI, 7'd0, 3'd0, 32'h00001000, 5'd0, 5'd0, 5'd8);
    idle();
    check("full_ready", 64'(o_ready), 64'd0);
    check("full_valid", 64'(o_valid), 64'd1);
    do_reset();
    check("post_rst_valid", 64'(o_valid), 64'd0);
    i_ready = 1'b1;

    // Random legal round trip with random backpressure.
    rand_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 1000; k++) rand_send();
        idle();
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          i_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    i_ready = 1'b1;
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
